// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the cpu_loader host-side memory initiator.
package cpu_loader_pkg;

  localparam int unsigned DEFAULT_IMEM_AW = 9;
  localparam int unsigned DEFAULT_DMEM_AW = 10;
  localparam int unsigned IMEM_STRIDE     = 4;
  localparam int unsigned DMEM_STRIDE     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoadI,
    StLoadD,
    StRun,
    StDumpRd,
    StDumpHold,
    StDone
  } state_e;

  // nz = {dump, run, dmem, imem} nonzero flags; picks the next phase after cur
  // that has work, or StDone when nothing remains.
  function automatic state_e next_phase(state_e cur, logic [3:0] nz);
    logic [3:0] m;
    case (cur)
      StIdle, StDone: m = 4'b1111;
      StLoadI:        m = 4'b1110;
      StLoadD:        m = 4'b1100;
      StRun:          m = 4'b1000;
      default:        m = 4'b0000;
    endcase
    m = m & nz;
    if (m[0]) return StLoadI;
    if (m[1]) return StLoadD;
    if (m[2]) return StRun;
    if (m[3]) return StDumpRd;
    return StDone;
  endfunction

endpackage

// File: rtl/ld_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
module ld_counter #(
  parameter int unsigned Width = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] count,
  output logic             last
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;
  // Only meaningful while limit is nonzero, which the FSM guarantees.
  assign last  = (count_q == limit - Width'(1));

endmodule

// File: rtl/cpu_loader.sv
// Loads imem/dmem images over a stream, runs the core for a set cycle count,
// then streams a region of dmem back out.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW = DEFAULT_IMEM_AW,
  parameter int unsigned DMEM_AW = DEFAULT_DMEM_AW
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic [IMEM_AW:0]   imem_len,
  input  logic [DMEM_AW:0]   dmem_len,
  input  logic [31:0]        run_cycles,
  input  logic [DMEM_AW:0]   dump_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [63:0]        s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [63:0]        m_data,
  output logic [63:0]        addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [31:0]        wdata_ext,
  input  logic [31:0]        rdata_ext,
  output logic [63:0]        addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [63:0]        wdata_ext_2,
  input  logic [63:0]        rdata_ext_2,
  output logic               cpu_enable,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = DMEM_AW + 1;

  state_e state_q, state_d;

  logic [IMEM_AW:0] imem_len_q;
  logic [DMEM_AW:0] dmem_len_q, dump_len_q;
  logic [31:0]      run_cycles_q;

  logic            latch;
  logic [3:0]      nz_in, nz_q;
  logic [CntW-1:0] cnt, cnt_limit;
  logic            cnt_last, cnt_clr, cnt_en;
  logic [31:0]     unused_run_cnt;
  logic            run_last;

  logic        m_valid_q, m_valid_d;
  logic [63:0] m_data_q, m_data_d;
  logic        cpu_enable_q, busy_q, done_q;

  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;

  assign nz_in = {dump_len != '0, run_cycles != '0, dmem_len != '0, imem_len != '0};
  assign nz_q  = {dump_len_q != '0, run_cycles_q != '0, dmem_len_q != '0, imem_len_q != '0};

  always_comb begin
    cnt_limit = '0;
    case (state_q)
      StLoadI:              cnt_limit = CntW'(imem_len_q);
      StLoadD:              cnt_limit = dmem_len_q;
      StDumpRd, StDumpHold: cnt_limit = dump_len_q;
      default:              cnt_limit = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    cnt_en    = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          latch   = 1'b1;
          state_d = next_phase(StIdle, nz_in);
        end
      end
      StLoadI, StLoadD: begin
        if (s_valid) begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = next_phase(state_q, nz_q);
        end
      end
      StRun: begin
        if (run_last) state_d = next_phase(StRun, nz_q);
      end
      StDumpRd: state_d = StDumpHold;
      StDumpHold: begin
        // First hold cycle captures the read data; m_valid rises after it.
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = rdata_ext_2;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_en    = 1'b1;
          state_d   = cnt_last ? StDone : StDumpRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word count restarts on every phase change except within the dump loop.
  assign cnt_clr = (state_d != state_q) && !(state_q == StDumpRd ||
                   (state_q == StDumpHold && state_d == StDumpRd));

  ld_counter #(.Width(CntW)) u_word_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .count  (cnt),
    .last   (cnt_last)
  );

  ld_counter #(.Width(32)) u_run_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (state_q != StRun),
    .en     (state_q == StRun),
    .limit  (run_cycles_q),
    .count  (unused_run_cnt),
    .last   (run_last)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= StIdle;
      imem_len_q   <= '0;
      dmem_len_q   <= '0;
      run_cycles_q <= '0;
      dump_len_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        imem_len_q   <= imem_len;
        dmem_len_q   <= dmem_len;
        run_cycles_q <= run_cycles;
        dump_len_q   <= dump_len;
      end
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      cpu_enable_q <= (state_d == StRun);
      busy_q       <= !(state_d inside {StIdle, StDone});
      done_q       <= (state_d == StDone);
    end
  end

  // Strobes are gated by reset so nothing reaches memory while it is held.
  logic in_load_i, in_load_d, in_dump_rd;
  assign in_load_i  = arst_n && (state_q == StLoadI);
  assign in_load_d  = arst_n && (state_q == StLoadD);
  assign in_dump_rd = arst_n && (state_q == StDumpRd);

  assign s_ready     = in_load_i || in_load_d;
  assign wen_ext     = in_load_i && s_valid;
  assign ren_ext     = 1'b0;
  assign addr_ext    = in_load_i ? 64'(cnt) * 64'(IMEM_STRIDE) : '0;
  assign wdata_ext   = in_load_i ? s_data[31:0] : '0;
  assign wen_ext_2   = in_load_d && s_valid;
  assign ren_ext_2   = in_dump_rd;
  assign addr_ext_2  = (in_load_d || in_dump_rd) ? 64'(cnt) * 64'(DMEM_STRIDE) : '0;
  assign wdata_ext_2 = in_load_d ? s_data : '0;

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign cpu_enable = cpu_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
